// File: rtl/umi_pkg.sv
// Shared definitions for the UMI device-side endpoint.
//   - UMI opcodes, taken from cmd[3:0]
//   - endpoint FSM state encoding
//   - opcode helpers: which request opcodes are supported, and the
//     response opcode that goes with a request
package umi_pkg;

   localparam logic [3:0] READ         = 4'h1;
   localparam logic [3:0] WRITE_POSTED = 4'h2;
   localparam logic [3:0] WRITE_ACK    = 4'h3;
   localparam logic [3:0] RESP_READ    = 4'h8;
   localparam logic [3:0] RESP_WRITE   = 4'h9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Only requests are terminated here.  Response opcodes arriving on the
   // request channel are treated as unsupported.
   function automatic logic op_supported(input logic [3:0] op);
      return (op == READ) || (op == WRITE_POSTED) || (op == WRITE_ACK);
   endfunction

   // Response opcode for an accepted request.  The rest of the response
   // command is the request command's upper bits.  The response addresses
   // are the request addresses swapped: dst <- src and src <- dst.
   function automatic logic [3:0] resp_opcode(input logic [3:0] req_op);
      return (req_op == READ) ? RESP_READ : RESP_WRITE;
   endfunction

endpackage

// File: rtl/umi_endpoint.sv
// UMI responder (device side).  It takes one UMI request at a time and
// turns it into a single-beat access on a simple local port.  It returns a
// UMI response for reads and for acknowledged writes.  Requests with an
// unsupported opcode are dropped and counted in err_count, which saturates.
//
// Ports:
//   clk, nreset          clock, synchronous active-low reset
//   udev_req_*           incoming request channel (valid/ready)
//   udev_resp_*          outgoing response channel (valid/ready)
//   loc_*                local register/memory port.  loc_rddata is valid
//                        1 cycle after the loc_read & loc_ready cycle.
//   err_count            saturating count of dropped requests
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | ready for a request; unsupported opcodes are dropped here
// ACCESS | drive the local strobe until loc_ready
// RDWAIT | capture loc_rddata (always exactly 1 cycle)
// RESP   | hold the registered response until udev_resp_ready
module umi_endpoint
   import umi_pkg::*;
#(
   parameter int AW = 64,
   parameter int CW = 32,
   parameter int UW = 256,
   parameter int DW = 64
)(
   input  logic          clk,
   input  logic          nreset,
   input  logic          udev_req_valid,
   input  logic [CW-1:0] udev_req_cmd,
   input  logic [AW-1:0] udev_req_dst_addr,
   input  logic [AW-1:0] udev_req_src_addr,
   input  logic [UW-1:0] udev_req_payload,
   output logic          udev_req_ready,
   output logic          udev_resp_valid,
   output logic [CW-1:0] udev_resp_cmd,
   output logic [AW-1:0] udev_resp_dst_addr,
   output logic [AW-1:0] udev_resp_src_addr,
   output logic [UW-1:0] udev_resp_payload,
   input  logic          udev_resp_ready,
   output logic [AW-1:0] loc_addr,
   output logic          loc_read,
   output logic          loc_write,
   output logic [DW-1:0] loc_wrdata,
   input  logic [DW-1:0] loc_rddata,
   input  logic          loc_ready,
   output logic [7:0]    err_count
);

   state_t        state;
   state_t        state_nxt;
   logic          running;
   logic          req_ready;
   logic          accept;
   logic [3:0]    op_in;
   logic [3:0]    op_q;
   logic [CW-1:0] cmd_q;
   logic [AW-1:0] dst_q;
   logic [AW-1:0] src_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic [7:0]    err_q;

   // running holds udev_req_ready low during reset.  It goes high the
   // first cycle after reset is released.
   assign req_ready      = (state == IDLE) && running;
   assign udev_req_ready = req_ready;
   assign accept         = udev_req_valid && req_ready;
   assign op_in          = udev_req_cmd[3:0];
   assign op_q           = cmd_q[3:0];
   assign err_count      = err_q;

   generate
      if (DW < UW) begin : g_payload_trim
         logic unused_payload_hi;
         assign unused_payload_hi = ^udev_req_payload[UW-1:DW];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state   <= IDLE;
         running <= 1'b0;
         cmd_q   <= '0;
         dst_q   <= '0;
         src_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= '0;
      end else begin
         state   <= state_nxt;
         running <= 1'b1;
         if (accept && op_supported(op_in)) begin
            cmd_q   <= udev_req_cmd;
            dst_q   <= udev_req_dst_addr;
            src_q   <= udev_req_src_addr;
            wdata_q <= udev_req_payload[DW-1:0];
            // Cleared here so that a write ack returns a zero payload.
            rdata_q <= '0;
         end
         if (state == RDWAIT) begin
            rdata_q <= loc_rddata;
         end
         if (accept && !op_supported(op_in) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
         end
      end
   end

   always_comb begin
      state_nxt          = state;
      loc_addr           = '0;
      loc_read           = 1'b0;
      loc_write          = 1'b0;
      loc_wrdata         = '0;
      udev_resp_valid    = 1'b0;
      udev_resp_cmd      = '0;
      udev_resp_dst_addr = '0;
      udev_resp_src_addr = '0;
      udev_resp_payload  = '0;
      case (state)
         IDLE: begin
            if (accept && op_supported(op_in)) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            loc_addr   = dst_q;
            loc_wrdata = wdata_q;
            loc_read   = (op_q == READ);
            loc_write  = (op_q != READ);
            if (loc_ready) begin
               if (op_q == READ) begin
                  state_nxt = RDWAIT;
               end else if (op_q == WRITE_ACK) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         RDWAIT: begin
            state_nxt = RESP;
         end
         RESP: begin
            udev_resp_valid                = 1'b1;
            udev_resp_cmd                  = {cmd_q[CW-1:4], resp_opcode(op_q)};
            udev_resp_dst_addr             = src_q;
            udev_resp_src_addr             = dst_q;
            udev_resp_payload[DW-1:0]      = rdata_q;
            if (udev_resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_umi_endpoint.sv
// Self-checking bench for umi_endpoint.  It has three parts:
//   - a table of single transactions with fixed latency expectations
//   - hand-written sequences for stalls, backpressure, error counter
//     saturation and reset in the middle of a transaction
//   - a randomized phase checked against a queue-based reference model
module tb_umi_endpoint;
   localparam int AW = 64;
   localparam int CW = 32;
   localparam int UW = 256;
   localparam int DW = 64;
   localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

   logic          clk = 1'b0;
   logic          nreset;
   logic          udev_req_valid;
   logic [CW-1:0] udev_req_cmd;
   logic [AW-1:0] udev_req_dst_addr;
   logic [AW-1:0] udev_req_src_addr;
   logic [UW-1:0] udev_req_payload;
   logic          udev_req_ready;
   logic          udev_resp_valid;
   logic [CW-1:0] udev_resp_cmd;
   logic [AW-1:0] udev_resp_dst_addr;
   logic [AW-1:0] udev_resp_src_addr;
   logic [UW-1:0] udev_resp_payload;
   logic          udev_resp_ready;
   logic [AW-1:0] loc_addr;
   logic          loc_read;
   logic          loc_write;
   logic [DW-1:0] loc_wrdata;
   logic [DW-1:0] loc_rddata;
   logic          loc_ready;
   logic [7:0]    err_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   umi_endpoint #(.AW(AW), .CW(CW), .UW(UW), .DW(DW)) dut (
      .clk                (clk),
      .nreset             (nreset),
      .udev_req_valid     (udev_req_valid),
      .udev_req_cmd       (udev_req_cmd),
      .udev_req_dst_addr  (udev_req_dst_addr),
      .udev_req_src_addr  (udev_req_src_addr),
      .udev_req_payload   (udev_req_payload),
      .udev_req_ready     (udev_req_ready),
      .udev_resp_valid    (udev_resp_valid),
      .udev_resp_cmd      (udev_resp_cmd),
      .udev_resp_dst_addr (udev_resp_dst_addr),
      .udev_resp_src_addr (udev_resp_src_addr),
      .udev_resp_payload  (udev_resp_payload),
      .udev_resp_ready    (udev_resp_ready),
      .loc_addr           (loc_addr),
      .loc_read           (loc_read),
      .loc_write          (loc_write),
      .loc_wrdata         (loc_wrdata),
      .loc_rddata         (loc_rddata),
      .loc_ready          (loc_ready),
      .err_count          (err_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.  Outputs are sampled
   // at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [UW-1:0] zext(input logic [DW-1:0] d);
      logic [UW-1:0] r;
      r = '0;
      r[DW-1:0] = d;
      return r;
   endfunction

   function automatic logic [UW-1:0] rand_payload();
      logic [UW-1:0] r;
      for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic idle_inputs();
      udev_req_valid    = 1'b0;
      udev_req_cmd      = '0;
      udev_req_dst_addr = '0;
      udev_req_src_addr = '0;
      udev_req_payload  = '0;
      udev_resp_ready   = 1'b1;
      loc_rddata        = GARBAGE;
      loc_ready         = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      nreset = 1'b0;
      step();
      step();
      nreset = 1'b1;
      step();
   endtask

   // ---------------- table-driven single transactions ----------------
   typedef struct {
      logic [3:0]  op;
      logic [63:0] dst;
      logic [63:0] src;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        exp_rd;
      logic        exp_wr;
      int          exp_lat;   // cycle of udev_resp_valid after accept, 0 = none
      logic [3:0]  exp_rop;
      logic [63:0] exp_pay;
      int          exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v, input int idx);
      logic [7:0]    err0;
      logic [CW-1:0] cmd;
      int            lat;
      err0 = err_count;
      cmd = $urandom();
      cmd[3:0] = v.op;
      udev_req_valid    = 1'b1;
      udev_req_cmd      = cmd;
      udev_req_dst_addr = v.dst;
      udev_req_src_addr = v.src;
      udev_req_payload  = rand_payload();
      udev_req_payload[63:0] = v.wdata;
      chk($sformatf("vec%0d_ready_c0", idx), 64'(udev_req_ready), 64'd1);
      step();
      udev_req_valid = 1'b0;
      loc_rddata     = GARBAGE;
      chk($sformatf("vec%0d_loc_read", idx), 64'(loc_read), 64'(v.exp_rd));
      chk($sformatf("vec%0d_loc_write", idx), 64'(loc_write), 64'(v.exp_wr));
      chk($sformatf("vec%0d_loc_addr", idx), loc_addr, (v.exp_rd || v.exp_wr) ? v.dst : 64'd0);
      if (v.exp_wr) chk($sformatf("vec%0d_wrdata", idx), loc_wrdata, v.wdata);
      chk($sformatf("vec%0d_ready_c1", idx), 64'(udev_req_ready),
          (v.exp_rd || v.exp_wr) ? 64'd0 : 64'd1);
      lat = 0;
      for (int k = 2; k <= 6; k++) begin
         step();
         loc_rddata = (k == 2) ? v.rdata : GARBAGE;
         if (k == 2 && v.exp_lat == 0)
            chk($sformatf("vec%0d_ready_c2", idx), 64'(udev_req_ready), 64'd1);
         if (udev_resp_valid && lat == 0) begin
            lat = k;
            chk($sformatf("vec%0d_resp_cmd", idx), 64'(udev_resp_cmd), 64'({cmd[CW-1:4], v.exp_rop}));
            chk($sformatf("vec%0d_resp_dst", idx), udev_resp_dst_addr, v.src);
            chk($sformatf("vec%0d_resp_src", idx), udev_resp_src_addr, v.dst);
            chk_w($sformatf("vec%0d_resp_pay", idx), udev_resp_payload, zext(v.exp_pay));
         end
      end
      chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
      chk($sformatf("vec%0d_err", idx), 64'(err_count), 64'(err0 + 8'(v.exp_err)));
   endtask

   // ---------------- randomized phase with reference model ----------------
   typedef struct {
      logic [3:0]    op;
      logic [AW-1:0] dst;
      logic [DW-1:0] data;
   } acc_t;

   typedef struct {
      logic [CW-1:0] cmd;
      logic [AW-1:0] dst;
      logic [AW-1:0] src;
      logic          is_read;
   } rsp_t;

   acc_t          acc_q[$];
   rsp_t          rsp_q[$];
   logic [DW-1:0] rd_q[$];

   task automatic random_phase(input int ncyc);
      int            unsup;
      int            exp_err;
      logic          rd_due;
      logic [DW-1:0] rd_val;
      logic          req_done;
      logic          held;
      logic [CW-1:0] h_cmd;
      logic [AW-1:0] h_dst;
      logic [AW-1:0] h_src;
      logic [UW-1:0] h_pay;
      logic [3:0]    op;
      logic [UW-1:0] exp_pay;
      acc_t          a;
      rsp_t          r;
      int            cyc;
      unsup = 0; rd_due = 0; req_done = 0; held = 0; rd_val = '0;
      cyc = 0;
      while (cyc < ncyc + 200) begin
         if (cyc >= ncyc && !udev_req_valid && !req_done &&
             acc_q.size() == 0 && rsp_q.size() == 0) break;
         step();
         cyc++;
         if (req_done) begin
            udev_req_valid = 1'b0;
            req_done = 0;
         end
         loc_rddata = rd_due ? rd_val : {$urandom(), $urandom()};
         rd_due = 0;

         // One transaction at a time: ready only when nothing is outstanding.
         if (udev_req_ready)
            chk("rnd_ready_idle", 64'(acc_q.size() + rsp_q.size()), 64'd0);

         if (loc_read || loc_write) begin
            loc_ready = ($urandom_range(0, 3) != 0);
            if (loc_ready) begin
               if (acc_q.size() == 0) begin
                  chk("rnd_unexpected_strobe", 64'd1, 64'd0);
               end else begin
                  a = acc_q.pop_front();
                  chk("rnd_loc_read", 64'(loc_read), 64'(a.op == 4'h1));
                  chk("rnd_loc_write", 64'(loc_write), 64'(a.op != 4'h1));
                  chk("rnd_loc_addr", loc_addr, a.dst);
                  if (a.op != 4'h1) chk("rnd_loc_wrdata", loc_wrdata, a.data);
                  if (a.op == 4'h1) begin
                     rd_val = {$urandom(), $urandom()};
                     rd_due = 1;
                     rd_q.push_back(rd_val);
                  end
               end
            end
         end else begin
            loc_ready = $urandom_range(0, 1);
         end

         if (udev_resp_valid) begin
            if (held) begin
               chk("rnd_stall_cmd", 64'(udev_resp_cmd), 64'(h_cmd));
               chk("rnd_stall_dst", udev_resp_dst_addr, h_dst);
               chk("rnd_stall_src", udev_resp_src_addr, h_src);
               chk_w("rnd_stall_pay", udev_resp_payload, h_pay);
            end
            udev_resp_ready = $urandom_range(0, 1);
            if (udev_resp_ready) begin
               held = 0;
               if (rsp_q.size() == 0) begin
                  chk("rnd_unexpected_resp", 64'd1, 64'd0);
               end else begin
                  r = rsp_q.pop_front();
                  exp_pay = '0;
                  if (r.is_read) begin
                     if (rd_q.size() == 0) chk("rnd_read_data_missing", 64'd1, 64'd0);
                     else exp_pay = zext(rd_q.pop_front());
                  end
                  chk("rnd_resp_cmd", 64'(udev_resp_cmd),
                      64'({r.cmd[CW-1:4], r.is_read ? 4'h8 : 4'h9}));
                  chk("rnd_resp_dst", udev_resp_dst_addr, r.src);
                  chk("rnd_resp_src", udev_resp_src_addr, r.dst);
                  chk_w("rnd_resp_pay", udev_resp_payload, exp_pay);
               end
            end else begin
               held = 1;
               h_cmd = udev_resp_cmd; h_dst = udev_resp_dst_addr;
               h_src = udev_resp_src_addr; h_pay = udev_resp_payload;
            end
         end else begin
            if (held) chk("rnd_resp_dropped", 64'd1, 64'd0);
            held = 0;
            udev_resp_ready = $urandom_range(0, 1);
         end

         if (!udev_req_valid && !req_done && cyc < ncyc && $urandom_range(0, 2) == 0) begin
            op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
            udev_req_valid    = 1'b1;
            udev_req_cmd      = $urandom();
            udev_req_cmd[3:0] = op;
            udev_req_dst_addr = {$urandom(), $urandom()};
            udev_req_src_addr = {$urandom(), $urandom()};
            udev_req_payload  = rand_payload();
         end
         if (udev_req_valid && !req_done && udev_req_ready) begin
            op = udev_req_cmd[3:0];
            if (op >= 4'h1 && op <= 4'h3) begin
               a.op = op; a.dst = udev_req_dst_addr; a.data = udev_req_payload[DW-1:0];
               acc_q.push_back(a);
               if (op != 4'h2) begin
                  r.cmd = udev_req_cmd; r.dst = udev_req_dst_addr;
                  r.src = udev_req_src_addr; r.is_read = (op == 4'h1);
                  rsp_q.push_back(r);
               end
            end else begin
               unsup++;
            end
            req_done = 1;
         end
      end
      chk("rnd_drain_acc", 64'(acc_q.size()), 64'd0);
      chk("rnd_drain_resp", 64'(rsp_q.size()), 64'd0);
      chk("rnd_drain_rd", 64'(rd_q.size()), 64'd0);
      exp_err = (unsup > 255) ? 255 : unsup;
      chk("rnd_err_count", 64'(err_count), 64'(exp_err));
      idle_inputs();
      step();
   endtask

   // ---------------- main sequence ----------------
   logic ok;

   initial begin
      vecs[0] = '{4'h1, 64'h1000, 64'h2000, 64'h0, 64'hDEADBEEF_01234567, 1'b1, 1'b0, 3, 4'h8, 64'hDEADBEEF_01234567, 0};
      vecs[1] = '{4'h3, 64'h3000, 64'h4000, 64'hA5A5, 64'h1111, 1'b0, 1'b1, 2, 4'h9, 64'h0, 0};
      vecs[2] = '{4'h2, 64'h5000, 64'h6000, 64'h0123_4567_89AB_CDEF, 64'h2222, 1'b0, 1'b1, 0, 4'h0, 64'h0, 0};
      vecs[3] = '{4'h7, 64'h7000, 64'h8000, 64'h3333, 64'h3333, 1'b0, 1'b0, 0, 4'h0, 64'h0, 1};
      vecs[4] = '{4'h8, 64'h9000, 64'hA000, 64'h4444, 64'h4444, 1'b0, 1'b0, 0, 4'h0, 64'h0, 1};
      vecs[5] = '{4'h1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h5555, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3, 4'h8, 64'hFFFF_FFFF_FFFF_FFFF, 0};
      vecs[6] = '{4'h0, 64'hB000, 64'hC000, 64'h6666, 64'h6666, 1'b0, 1'b0, 0, 4'h0, 64'h0, 1};
      vecs[7] = '{4'h3, 64'h0, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7777, 1'b0, 1'b1, 2, 4'h9, 64'h0, 0};

      // Reset: every output low, ready rises the cycle after release.
      idle_inputs();
      nreset = 1'b0;
      step();
      step();
      chk("rst_ready", 64'(udev_req_ready), 64'd0);
      chk("rst_resp_valid", 64'(udev_resp_valid), 64'd0);
      chk("rst_loc_strobes", 64'({loc_read, loc_write}), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      nreset = 1'b1;
      chk("rst_ready_release", 64'(udev_req_ready), 64'd0);
      step();
      chk("rst_ready_after", 64'(udev_req_ready), 64'd1);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // WRITE_ACK with loc_ready low for 3 cycles: the strobe is held 4 cycles.
      udev_req_valid = 1'b1; udev_req_cmd = 32'h0000_0003;
      udev_req_dst_addr = 64'h5500; udev_req_src_addr = 64'h6600;
      udev_req_payload = rand_payload(); udev_req_payload[63:0] = 64'hA5A5;
      loc_ready = 1'b0;
      step();
      udev_req_valid = 1'b0;
      ok = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         if (!loc_write || loc_read || loc_wrdata !== 64'hA5A5 || loc_addr !== 64'h5500) ok = 1'b0;
         loc_ready = (j == 4);
         step();
      end
      chk("stall_strobe_held", 64'(ok), 64'd1);
      chk("stall_strobe_off", 64'(loc_write), 64'd0);
      chk("stall_resp_valid", 64'(udev_resp_valid), 64'd1);
      chk("stall_resp_op", 64'(udev_resp_cmd[3:0]), 64'h9);
      chk_w("stall_resp_pay", udev_resp_payload, '0);
      step();
      chk("stall_ready_back", 64'(udev_req_ready), 64'd1);

      // 300 back-to-back unsupported requests.
      do_reset();
      udev_req_valid = 1'b1; udev_req_cmd = 32'h0000_0007;
      ok = 1'b1;
      for (int j = 0; j < 300; j++) begin
         if (j == 10) chk("unsup_err_10", 64'(err_count), 64'd10);
         if (loc_read || loc_write || udev_resp_valid || !udev_req_ready) ok = 1'b0;
         step();
      end
      udev_req_valid = 1'b0;
      chk("unsup_quiet", 64'(ok), 64'd1);
      chk("unsup_err_sat", 64'(err_count), 64'hFF);
      step();
      chk("unsup_err_hold", 64'(err_count), 64'hFF);

      // Read with 10 cycles of response backpressure and a pending request.
      udev_req_valid = 1'b1; udev_req_cmd = 32'h1234_5671;
      udev_req_dst_addr = 64'h7000; udev_req_src_addr = 64'h8000;
      udev_resp_ready = 1'b0;
      step();
      udev_req_cmd = 32'h0000_0002; udev_req_dst_addr = 64'h9000;
      udev_req_payload = '0; udev_req_payload[63:0] = 64'h1234;
      step();
      loc_rddata = 64'hCAFE_F00D_1234_5678;
      step();
      loc_rddata = GARBAGE;
      ok = 1'b1;
      for (int j = 0; j < 10; j++) begin
         if (!udev_resp_valid || udev_req_ready || udev_resp_cmd !== 32'h1234_5678 ||
             udev_resp_dst_addr !== 64'h8000 || udev_resp_src_addr !== 64'h7000 ||
             udev_resp_payload !== zext(64'hCAFE_F00D_1234_5678)) ok = 1'b0;
         if (j == 9) udev_resp_ready = 1'b1;
         step();
      end
      chk("bp_resp_stable", 64'(ok), 64'd1);
      chk("bp_resp_done", 64'(udev_resp_valid), 64'd0);
      chk("bp_ready_after", 64'(udev_req_ready), 64'd1);
      step();
      udev_req_valid = 1'b0;
      chk("bp_next_write", 64'(loc_write), 64'd1);
      chk("bp_next_addr", loc_addr, 64'h9000);
      chk("bp_next_data", loc_wrdata, 64'h1234);
      step();

      // Reset while in ACCESS abandons the read; the next read completes.
      udev_req_valid = 1'b1; udev_req_cmd = 32'h0000_0001;
      udev_req_dst_addr = 64'hE000; udev_req_src_addr = 64'hF000;
      loc_ready = 1'b0;
      step();
      udev_req_valid = 1'b0;
      chk("mid_rst_access", 64'(loc_read), 64'd1);
      nreset = 1'b0;
      step();
      chk("mid_rst_outputs", 64'({udev_req_ready, udev_resp_valid, loc_read, loc_write}), 64'd0);
      chk("mid_rst_addr", loc_addr, 64'd0);
      chk("mid_rst_err", 64'(err_count), 64'd0);
      nreset = 1'b1; loc_ready = 1'b1;
      step();
      chk("mid_rst_no_resp", 64'(udev_resp_valid), 64'd0);
      run_vec(vecs[0], 8);

      // Randomized traffic against the queue model, from a clean reset.
      do_reset();
      random_phase(4000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/umi_endpoint.md
Name: umi_endpoint

Overview:
UMI responder (device side) that terminates a UMI request stream and converts it into single-beat accesses on a simple local register/memory port. It generates UMI responses for reads and acknowledged writes, and sits behind an async UMI FIFO on the device side of a link. It processes one transaction at a time with a blocking request handshake. Unsupported opcodes are dropped and counted.

Parameters:
AW, 64, UMI address width
CW, 32, UMI command width (min 8)
UW, 256, UMI payload width
DW, 64, local data width; DW <= UW

Ports:
clk  in  1  clock for all logic
nreset  in  1  synchronous active-low reset
udev_req_valid  in  1  request valid
udev_req_cmd  in  CW  request command; [3:0] opcode
udev_req_dst_addr  in  AW  target address
udev_req_src_addr  in  AW  requester return address
udev_req_payload  in  UW  write data; [DW-1:0] used
udev_req_ready  out  1  request accepted when valid&ready
udev_resp_valid  out  1  response valid
udev_resp_cmd  out  CW  response command
udev_resp_dst_addr  out  AW  equals request src_addr
udev_resp_src_addr  out  AW  equals request dst_addr
udev_resp_payload  out  UW  read data, zero-extended
udev_resp_ready  in  1  response accepted when valid&ready
loc_addr  out  AW  local access address
loc_read  out  1  local read strobe
loc_write  out  1  local write strobe
loc_wrdata  out  DW  local write data
loc_rddata  in  DW  read data, valid exactly 1 cycle after the loc_read&loc_ready cycle
loc_ready  in  1  local port accepts the strobe this cycle
err_count  out  8  saturating count of dropped requests

Behaviour:
- Clock and reset: single clock `clk`. Reset `nreset` is synchronous, active-low.
- Opcodes (cmd[3:0]):
  - READ = 4'h1
  - WRITE_POSTED = 4'h2
  - WRITE_ACK = 4'h3
  - RESP_READ = 4'h8
  - RESP_WRITE = 4'h9
  - All other values are unsupported.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including err_count and udev_req_ready.
  - udev_req_ready rises the first cycle after reset deasserts.
  - Reset mid-transaction abandons the transaction with no response.
- IDLE:
  - udev_req_ready = 1.
  - On handshake with a supported opcode, register cmd, dst_addr, src_addr and payload[DW-1:0]; go to ACCESS.
  - On handshake with an unsupported opcode, drop the request, stay in IDLE, and increment err_count (saturates at 8'hFF).
- ACCESS:
  - udev_req_ready = 0.
  - loc_addr = registered dst_addr; loc_wrdata = registered data.
  - loc_read = 1 for READ; loc_write = 1 for either write opcode.
  - Strobes hold until loc_ready = 1.
  - On loc_ready: READ goes to RDWAIT, WRITE_ACK goes to RESP, WRITE_POSTED goes to IDLE.
- RDWAIT: capture loc_rddata into the response payload register; go to RESP. Lasts exactly 1 cycle.
- RESP:
  - udev_resp_valid = 1. All resp fields are registered and stable while valid.
  - resp_cmd = {req_cmd[CW-1:4], RESP_READ or RESP_WRITE}.
  - resp_payload = {zeros, rddata} for a read; 0 for a write ack.
  - On udev_resp_ready, go to IDLE. The next request cannot be accepted in the same cycle.
- Latency with loc_ready tied high:
  - Read: request accepted at cycle 0, strobe at cycle 1, resp_valid at cycle 3.
  - Write ack: request accepted at cycle 0, resp_valid at cycle 2.
  - Posted write: udev_req_ready returns at cycle 2.
- Outputs are 0 whenever not in their active state: loc_* only meaningful in ACCESS, udev_resp_* only in RESP. Avoids X propagation in simulation.
- Backpressure: udev_resp_ready held low stalls in RESP indefinitely; no request is accepted meanwhile.
- Width rule: if DW < UW, payload bits above DW are ignored on input and driven to zero on output.

Decomposition:
- Shared package umi_pkg holds the opcode localparams (READ, WRITE_POSTED, WRITE_ACK, RESP_READ, RESP_WRITE) and the FSM state encoding.
- Response cmd/addr swap helper belongs in the package as a function.
- No sub-module is natural; the FSM and datapath registers are implemented inline.

Test Plan:
- Read, loc_ready = 1, loc_rddata = 64'hDEADBEEF_01234567, dst = 64'h1000, src = 64'h2000 -> loc_read at cycle 1 with addr 64'h1000. Response at cycle 3: cmd[3:0] = 4'h8, dst = 64'h2000, src = 64'h1000, payload[63:0] = DEADBEEF_01234567, upper payload bits 0.
- WRITE_ACK, data 64'hA5A5, loc_ready low for 3 cycles -> loc_write and loc_wrdata = 64'hA5A5 held 4 cycles. Response cmd[3:0] = 4'h9, payload 0.
- WRITE_POSTED -> single loc_write, no udev_resp_valid ever asserted. udev_req_ready high again 2 cycles after accept.
- Unsupported opcode 4'h7 sent 300 times back-to-back -> no loc strobes, no responses; err_count saturates at 8'hFF.
- Read with udev_resp_ready low for 10 cycles, new request pending -> response stable for all 10 cycles; udev_req_ready = 0 until the cycle after the response handshake.
- nreset asserted while in ACCESS -> next cycle all outputs 0 and state IDLE. A following read completes normally.
